uart_tx_fifo: RTL

//   Byte FIFO and frame pacer in front of the UART transmitter (uat_top).
//   - Upstream logic pushes bytes at CLK rate; the block stores up to DEPTH bytes.
//   - It releases one byte per frame time on tx_rdy/tx_byte (-> uat_top din_rdy/din_byte).
//   - tx_rdy is held long enough for the slow clk_x domain to sample it.
//   - The gap between releases guarantees the previous frame has finished shifting out.

---
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO plus frame pacer that sits in front of the UART transmitter.
//   Upstream logic pushes bytes at CLK rate. The pacer releases at most one
//   byte per frame time on tx_rdy/tx_byte. tx_rdy is held high long enough for
//   the slow transmitter clock domain to sample it. The gap that follows the
//   pulse makes sure the previous frame has finished shifting out before the
//   next byte is offered.
//
// Ports
//   CLK       in   system clock
//   rst_n     in   asynchronous active-low reset
//   wr_en     in   push wr_data this cycle (dropped if full)
//   wr_data   in   byte to transmit
//   flush     in   synchronous clear of FIFO contents and overflow
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  bytes currently stored, 0..DEPTH
//   overflow  out  sticky: a write was dropped while full
//   tx_rdy    out  data-ready to transmitter, high HOLD_CYCLES per byte
//   tx_byte   out  byte being released, stable until the next release
//   busy      out  pacer is in SEND or GAP
//
// Handshake: there is no backpressure from the transmitter. A byte is
// "offered" for exactly HOLD_CYCLES cycles on tx_rdy, and tx_byte stays
// valid from the release until the next release. Upstream sees only
// full/overflow; a write while full is lost and recorded in overflow.
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int HOLD_CYCLES  = 41664,
    parameter int FRAME_CYCLES = 458304,
    parameter int TW           = 19
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          tx_rdy,
    output logic [7:0]    tx_byte,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            accept;
    logic            pop;

    // full/empty decode the registered count, so they reflect the state at
    // the start of the cycle; a write in the same cycle as a pop while full
    // is still dropped.
    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign busy   = (state != IDLE);
    assign accept = wr_en && !full;
    assign pop    = (state == IDLE) && !empty && !flush;

    // Storage array carries no reset: pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (accept && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and overflow. Flush wins over write and pop.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Pacer. The timer runs from the release through SEND and GAP, so a
    // full frame is FRAME_CYCLES long; IDLE adds one cycle between frames.
    // Flush does not touch this block, so an in-flight frame completes.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            tx_rdy  <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    tx_rdy <= 1'b0;
                    if (pop) begin
                        tx_byte <= mem[rd_ptr];
                        timer   <= '0;
                        tx_rdy  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    timer <= timer + 1'b1;
                    if (timer == HOLD_LAST) begin
                        tx_rdy <= 1'b0;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    timer <= timer + 1'b1;
                    if (timer == FRAME_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_rdy <= 1'b0;
                    timer  <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
